// File: rtl/gcm_pkg.sv
// Shared types and constants for the AES-GCM block feeder.
// Word and block geometry plus the feeder state encoding.
package gcm_pkg;

    localparam int GCM_BLOCK_W     = 128;
    localparam int GCM_WORD_W      = 32;
    localparam int WORDS_PER_BLOCK = GCM_BLOCK_W / GCM_WORD_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } gcm_state_e;

endpackage

// File: rtl/gcm_word_packer.sv
// Packs a word stream into one block, first word in the leftmost slot.
// A short final word zero-fills the remaining slots; i_clear empties the block.
module gcm_word_packer
    import gcm_pkg::*;
#(
    parameter int WORD_W  = GCM_WORD_W,
    parameter int BLOCK_W = GCM_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic               i_last,
    input  logic               i_clear,
    input  logic [0:WORD_W-1]  i_word,
    output logic [0:BLOCK_W-1] o_block,
    output logic               o_done
);

    localparam int N_SLOTS = BLOCK_W / WORD_W;
    localparam int IDX_W   = $clog2(N_SLOTS);

    logic [IDX_W-1:0]   r_idx;
    logic [0:BLOCK_W-1] r_block;
    logic               w_full;

    assign w_full  = (r_idx == IDX_W'(N_SLOTS - 1));
    assign o_done  = i_wr && (i_last || w_full);
    assign o_block = r_block;

    // Slot index: advances per written word, restarts when a block closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_wr) begin
            r_idx <= o_done ? '0 : r_idx + 1'b1;
        end
    end

    // Block storage: write current slot, zero every slot after it on i_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block <= '0;
        end else if (i_clear) begin
            r_block <= '0;
        end else if (i_wr) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (IDX_W'(s) == r_idx) begin
                    r_block[s*WORD_W +: WORD_W] <= i_word;
                end else if (i_last && (IDX_W'(s) > r_idx)) begin
                    r_block[s*WORD_W +: WORD_W] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/gcm_block_feeder.sv
// Feeds packed plaintext/passby blocks to the GCM core, one in flight at a time.
// Holds each block until cipher-ready; a watchdog flags a core that never answers.
module gcm_block_feeder
    import gcm_pkg::*;
#(
    parameter int WORD_W   = GCM_WORD_W,
    parameter int BLOCK_W  = GCM_BLOCK_W,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [0:WORD_W-1]  i_word,
    input  logic [0:WORD_W-1]  i_passby_word,
    input  logic               i_last,
    output logic               o_new,
    output logic [0:BLOCK_W-1] o_plain_text,
    output logic [0:BLOCK_W-1] o_passby_text,
    input  logic               i_cp_ready,
    output logic               o_busy,
    output logic               o_timeout,
    output logic [CNT_W-1:0]   o_block_count
);

    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    gcm_state_e         r_state;
    gcm_state_e         w_next;
    logic               w_fill;
    logic               w_accept;
    logic               w_pt_done;
    logic               w_pb_done;
    logic               w_done;
    logic               w_complete;
    logic               w_expire;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_count;

    // Readiness is forced low while reset is asserted, not just after it.
    assign w_fill        = (r_state == FILL);
    assign o_ready       = w_fill && rst_n;
    assign w_accept      = i_valid && o_ready;
    assign w_done        = w_pt_done && w_pb_done;
    assign o_timeout     = r_timeout;
    assign o_block_count = r_count;

    gcm_word_packer #(
        .WORD_W  (WORD_W),
        .BLOCK_W (BLOCK_W)
    ) u_pt_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_accept),
        .i_last  (i_last),
        .i_clear (w_complete),
        .i_word  (i_word),
        .o_block (o_plain_text),
        .o_done  (w_pt_done)
    );

    gcm_word_packer #(
        .WORD_W  (WORD_W),
        .BLOCK_W (BLOCK_W)
    ) u_pb_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_accept),
        .i_last  (i_last),
        .i_clear (w_complete),
        .i_word  (i_passby_word),
        .o_block (o_passby_text),
        .o_done  (w_pb_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-state outputs; cp_ready wins over an expiring watchdog.
    always_comb begin
        w_next     = r_state;
        o_new      = 1'b0;
        o_busy     = 1'b0;
        w_complete = 1'b0;
        w_expire   = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_done) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                o_new  = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_cp_ready) begin
                    w_complete = 1'b1;
                    w_next     = FILL;
                end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
                    w_expire   = 1'b1;
                    w_complete = 1'b1;
                    w_next     = FILL;
                end
            end
            default: begin
                w_next = FILL;
            end
        endcase
    end

    // Watchdog: counts WAIT cycles, idles at zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (o_busy && !w_complete) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end
    end

    // Completed-block counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_complete) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gcm_block_feeder.sv
// Self-checking bench for gcm_block_feeder.
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_gcm_block_feeder;

    localparam int MW   = 8;
    localparam int CW   = 2;
    localparam int CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_valid;
    logic          o_ready;
    logic [0:31]   i_word;
    logic [0:31]   i_passby_word;
    logic          i_last;
    logic          o_new;
    logic [0:127]  o_plain_text;
    logic [0:127]  o_passby_text;
    logic          i_cp_ready;
    logic          o_busy;
    logic          o_timeout;
    logic [CW-1:0] o_block_count;

    int n_chk;
    int n_pass;

    logic [31:0]  mq_pt[$];
    logic [31:0]  mq_pb[$];
    logic [127:0] m_pt;
    logic [127:0] m_pb;
    bit           m_issue;
    int           m_age;
    bit           m_to;
    int           m_cnt;

    gcm_block_feeder #(
        .WORD_W   (32),
        .BLOCK_W  (128),
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_word        (i_word),
        .i_passby_word (i_passby_word),
        .i_last        (i_last),
        .o_new         (o_new),
        .o_plain_text  (o_plain_text),
        .o_passby_text (o_passby_text),
        .i_cp_ready    (i_cp_ready),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .o_block_count (o_block_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [31:0] q[$]);
        logic [127:0] r;
        r = '0;
        foreach (q[i]) r[127-32*i -: 32] = q[i];
        return r;
    endfunction

    task automatic m_reset();
        mq_pt.delete();
        mq_pb.delete();
        m_pt    = '0;
        m_pb    = '0;
        m_issue = 1'b0;
        m_age   = -1;
        m_to    = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: check outputs against the model, drive, then advance the model.
    task automatic step(input bit v, input logic [31:0] w,
                        input logic [31:0] pw, input bit l, input bit cp);
        bit fill;
        @(negedge clk);
        fill = !m_issue && (m_age < 0);
        chk("ready", 128'(o_ready), 128'(fill));
        chk("new", 128'(o_new), 128'(m_issue));
        chk("busy", 128'(o_busy), 128'(m_age >= 0));
        chk("plain", o_plain_text, m_pt);
        chk("passby", o_passby_text, m_pb);
        chk("timeout", 128'(o_timeout), 128'(m_to));
        chk("count", 128'(o_block_count), 128'(m_cnt % CMOD));
        i_valid       = v;
        i_word        = w;
        i_passby_word = pw;
        i_last        = l;
        i_cp_ready    = cp;
        @(posedge clk);
        if (fill) begin
            if (v) begin
                mq_pt.push_back(w);
                mq_pb.push_back(pw);
                m_pt = pack(mq_pt);
                m_pb = pack(mq_pb);
                if (l || mq_pt.size() == 4) begin
                    m_issue = 1'b1;
                    mq_pt.delete();
                    mq_pb.delete();
                end
            end
        end else if (m_issue) begin
            m_issue = 1'b0;
            m_age   = 0;
        end else if (cp || m_age == MW - 1) begin
            if (!cp) m_to = 1'b1;
            m_cnt++;
            m_age = -1;
            m_pt  = '0;
            m_pb  = '0;
        end else begin
            m_age++;
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n         = 1'b0;
        i_valid       = 1'b0;
        i_word        = '0;
        i_passby_word = '0;
        i_last        = 1'b0;
        i_cp_ready    = 1'b0;
        #1;
        chk("rst_ready", 128'(o_ready), 128'(0));
        chk("rst_new", 128'(o_new), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_plain", o_plain_text, 128'(0));
        chk("rst_passby", o_passby_text, 128'(0));
        chk("rst_timeout", 128'(o_timeout), 128'(0));
        chk("rst_count", 128'(o_block_count), 128'(0));
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic full_block(input logic [31:0] base);
        for (int k = 0; k < 4; k++) step(1, base + 32'(k), ~(base + 32'(k)), 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [127:0] exp_blk;
        n_chk  = 0;
        n_pass = 0;
        #1;
        do_reset();

        step(1, 32'h00112233, 32'hA0000001, 0, 0);
        step(1, 32'h44556677, 32'hA0000002, 0, 0);
        step(1, 32'h8899AABB, 32'hA0000003, 0, 0);
        step(1, 32'hCCDDEEFF, 32'hA0000004, 0, 0);
        #1;
        chk("t1_new", 128'(o_new), 128'(1));
        chk("t1_plain", o_plain_text,
            128'h00112233_44556677_8899AABB_CCDDEEFF);
        step(1, 32'h55555555, 32'h66666666, 0, 0);
        step(1, 32'h55555555, 32'h66666666, 0, 0);
        step(1, 32'h55555555, 32'h66666666, 0, 0);
        step(1, 32'h55555555, 32'h66666666, 0, 1);
        #1;
        chk("t3_busy", 128'(o_busy), 128'(0));
        chk("t3_ready", 128'(o_ready), 128'(1));
        chk("t3_count", 128'(o_block_count), 128'(1));
        chk("t3_plain", o_plain_text, 128'(0));

        step(1, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0);
        #1;
        chk("t2_new", 128'(o_new), 128'(1));
        chk("t2_plain", o_plain_text, 128'hDEADBEEF_00000000_00000000_00000000);
        chk("t2_passby", o_passby_text, 128'hCAFEF00D_00000000_00000000_00000000);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < MW - 1; k++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        #1;
        chk("t4_edge_timeout", 128'(o_timeout), 128'(0));
        chk("t4_edge_count", 128'(o_block_count), 128'(2 % CMOD));

        for (int b = 0; b < 2; b++) begin
            exp_blk = '0;
            for (int k = 0; k < 7; k++) begin
                step((k % 2) == 0, 32'h10000000 + 32'(b * 16 + k),
                     32'h20000000 + 32'(b * 16 + k), 0, 0);
                if (k % 2 == 0)
                    exp_blk[127-16*k -: 32] = 32'h10000000 + 32'(b * 16 + k);
            end
            #1;
            chk("t5_plain", o_plain_text, exp_blk);
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1);
        end
        #1;
        chk("t5_count", 128'(o_block_count), 128'(4 % CMOD));

        for (int k = 0; k < 4; k++) step(1, 32'h300 + 32'(k), 32'h400 + 32'(k), 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < MW - 1; k++) step(0, 0, 0, 0, 0);
        #1;
        chk("t4_pre_timeout", 128'(o_timeout), 128'(0));
        step(0, 0, 0, 0, 0);
        #1;
        chk("t4_timeout", 128'(o_timeout), 128'(1));
        chk("t4_count", 128'(o_block_count), 128'(5 % CMOD));
        full_block(32'h500);
        #1;
        chk("t4_sticky", 128'(o_timeout), 128'(1));

        repeat (1500) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end

        do_reset();
        step(1, 32'hBAD00001, 32'hBAD10001, 0, 0);
        step(1, 32'hBAD00002, 32'hBAD10002, 0, 0);
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 32'h70 + 32'(k), 32'h80 + 32'(k), 0, 0);
        #1;
        chk("t6_clean", o_plain_text,
            128'h00000070_00000071_00000072_00000073);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int b = 1; b < 5; b++) full_block(32'h900 + 32'(b * 8));
        #1;
        chk("t6_wrap", 128'(o_block_count), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
